// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Data-memory access stage. Issues one req/ack bus transaction per
//            accepted load/store, formats load data (lane select plus sign or
//            zero extension) for register write-back, and raises busy while a
//            transaction is in flight.
// Ports    : clk, reset (async, active-high)
//            start/load/store/funct3/addr/wdata/rd_in  - request from core
//            busy/done/err/rdata_out/rd_out/wr_en_out  - status and write-back
//            mem_req/mem_we/mem_addr/mem_wdata/mem_be  - bus request (registered)
//            mem_ack/mem_rdata                         - bus response
// Options  : `define MISALIGN_TRAP_EN to trap misaligned half/word accesses
//            (no bus cycle, err=1). Undefined: low address bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata_out,
    output logic [4:0]        rd_out,
    output logic              wr_en_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Counter holds 0..TIMEOUT-1; reaching TIMEOUT-1 without ack ends the wait.
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_funct3;
    logic [1:0]          r_lo;
    logic [4:0]          r_rd;
    logic                r_is_load;
    logic                r_err;
    logic [31:0]         r_rdata_out;
    logic [4:0]          r_rd_out;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_be;

    logic                w_accept;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_trap;
    logic                w_timeout;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_fmt;

    assign w_accept = (r_state == c_IDLE) && start && (load || store);

    // Load has priority, so legality is judged against the load table when
    // both direction bits are set.
    assign w_illegal = load ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                            : (funct3[2] || (funct3[1:0] == 2'b11));

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_trap    = w_illegal || w_misalign;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_W'(c_LIMIT));

    // Byte enables and lane-replicated store data. For halves only addr[1]
    // selects the lane; a set addr[0] is either trapped or ignored.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
    end

    // Load formatting from the captured lane offset and size/sign code.
    always_comb begin
        w_byte     = mem_rdata[{r_lo, 3'b000} +: 8];
        w_half     = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_fmt = mem_rdata;
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next = w_trap ? c_RESP : c_REQ;
                end
            end
            c_REQ: begin
                if (mem_ack || w_timeout) begin
                    w_next = c_RESP;
                end
            end
            c_RESP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (r_state != c_IDLE);
        done      = (r_state == c_RESP);
        err       = done && r_err;
        wr_en_out = done && r_is_load && !r_err;
    end

    // Datapath and registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_funct3    <= 3'd0;
            r_lo        <= 2'd0;
            r_rd        <= 5'd0;
            r_is_load   <= 1'b0;
            r_err       <= 1'b0;
            r_rdata_out <= 32'd0;
            r_rd_out    <= 5'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
        end else begin
            r_mem_req <= (w_next == c_REQ);

            if ((r_state == c_REQ) && (w_next == c_REQ)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_accept) begin
                r_funct3  <= funct3;
                r_lo      <= addr[1:0];
                r_rd      <= rd_in;
                r_is_load <= load;
                r_err     <= w_trap;
                if (!w_trap) begin
                    r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    r_mem_we    <= !load;
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                end
            end

            if (r_state == c_REQ) begin
                if (mem_ack) begin
                    // Write-back data only changes when a load completes.
                    if (r_is_load) begin
                        r_rdata_out <= w_load_fmt;
                        r_rd_out    <= r_rd;
                    end
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign rdata_out = r_rdata_out;
    assign rd_out    = r_rd_out;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit. Expected
//            write-back results are queued when a request is issued and popped
//            when the unit signals done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata_out;
    logic [4:0]  rd_out;
    logic        wr_en_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    load_store_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load      (load),
        .store     (store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata_out (rdata_out),
        .rd_out    (rd_out),
        .wr_en_out (wr_en_out),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. Called 1 time unit after a rising edge.
    task automatic txn(input string tag, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] rdat, input int ack_dly,
                       input logic bus, input logic [3:0] ebe,
                       input logic [31:0] eaddr, input logic [31:0] ewdata,
                       input exp_t e);
        exp_t got;
        start  = 1'b1;
        load   = ld;
        store  = st;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        rd_in  = rd;
        sb.push_back(e);
        step();
        start = 1'b0;
        load  = 1'b0;
        store = 1'b0;
        if (bus) begin
            chk({tag, ".req"}, mem_req, 1'b1);
            chk({tag, ".addr"}, mem_addr, eaddr);
            chk({tag, ".be"}, mem_be, ebe);
            chk({tag, ".we"}, mem_we, !ld);
            if (!ld) chk({tag, ".wdata"}, mem_wdata, ewdata);
            repeat (ack_dly) step();
            chk({tag, ".req_hold"}, mem_req, 1'b1);
            mem_ack   = 1'b1;
            mem_rdata = rdat;
            step();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end else begin
            chk({tag, ".nobus"}, mem_req, 1'b0);
        end
        chk({tag, ".done"}, done, 1'b1);
        if (done === 1'b1 && sb.size() > 0) begin
            got = sb.pop_front();
            chk({tag, ".err"}, err, got.err);
            chk({tag, ".wr_en"}, wr_en_out, got.wr);
            chk({tag, ".rdata"}, rdata_out, got.rdata);
            chk({tag, ".rd"}, rd_out, got.rd);
        end else begin
            sb.delete();
        end
        step();
        chk({tag, ".done_clr"}, done, 1'b0);
        chk({tag, ".idle"}, busy, 1'b0);
    endtask

    initial begin : stim
        int   n;
        int   guard;
        logic saw_done;

        reset = 1'b1; start = 1'b0; load = 1'b0; store = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0; rd_in = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.req", mem_req, 1'b0);
        chk("rst.rdata", rdata_out, 32'd0);
        chk("rst.be", mem_be, 4'd0);
        chk("rst.addr", mem_addr, 32'd0);
        reset = 1'b0;
        step();

        // Stray ack while idle must do nothing.
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("idle_ack.done", done, 1'b0);
        chk("idle_ack.busy", busy, 1'b0);

        txn("lw",  1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 1, 4'b1111, 32'h100, 32'h0,
            '{32'hDEADBEEF, 5'd5, 1'b0, 1'b1});
        txn("lb",  1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 32'h80FF1234, 1, 1, 4'b1000, 32'h100, 32'h0,
            '{32'hFFFFFF80, 5'd6, 1'b0, 1'b1});
        txn("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF1234, 0, 1, 4'b1000, 32'h100, 32'h0,
            '{32'h00000080, 5'd7, 1'b0, 1'b1});
        txn("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 5'd8, 32'h80FF1234, 2, 1, 4'b1100, 32'h100, 32'h0,
            '{32'h000080FF, 5'd8, 1'b0, 1'b1});
        txn("lh",  1, 0, 3'b001, 32'h100, 32'h0, 5'd9, 32'h12348001, 3, 1, 4'b0011, 32'h100, 32'h0,
            '{32'hFFFF8001, 5'd9, 1'b0, 1'b1});
        txn("sb",  0, 1, 3'b000, 32'h21, 32'h000000A5, 5'd1, 32'h0, 0, 1, 4'b0010, 32'h20, 32'hA5A5A5A5,
            '{32'hFFFF8001, 5'd9, 1'b0, 1'b0});
        txn("sh",  0, 1, 3'b001, 32'h22, 32'h1234ABCD, 5'd2, 32'h0, 1, 1, 4'b1100, 32'h20, 32'hABCDABCD,
            '{32'hFFFF8001, 5'd9, 1'b0, 1'b0});
        txn("sw",  0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd2, 32'h0, 0, 1, 4'b1111, 32'h40, 32'hCAFEF00D,
            '{32'hFFFF8001, 5'd9, 1'b0, 1'b0});
        txn("ill_ld", 1, 0, 3'b011, 32'h80, 32'h0, 5'd4, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0,
            '{32'hFFFF8001, 5'd9, 1'b1, 1'b0});
        txn("ill_st", 0, 1, 3'b100, 32'h80, 32'h0, 5'd4, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0,
            '{32'hFFFF8001, 5'd9, 1'b1, 1'b0});
        txn("ld_pri", 1, 1, 3'b010, 32'h80, 32'hFFFFFFFF, 5'd3, 32'h11223344, 0, 1, 4'b1111, 32'h80, 32'h0,
            '{32'h11223344, 5'd3, 1'b0, 1'b1});
`ifdef MISALIGN_TRAP_EN
        txn("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 5'd10, 32'h55667788, 0, 0, 4'b0, 32'h0, 32'h0,
            '{32'h11223344, 5'd3, 1'b1, 1'b0});
`else
        txn("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 5'd10, 32'h55667788, 0, 1, 4'b1111, 32'h100, 32'h0,
            '{32'h55667788, 5'd10, 1'b0, 1'b1});
`endif

        // start while busy is dropped, not queued.
        start = 1'b1; load = 1'b1; funct3 = 3'b010; addr = 32'h200; rd_in = 5'd12;
        step();
        addr = 32'h300; rd_in = 5'd13;
        chk("busy_st.req", mem_req, 1'b1);
        step();
        start = 1'b0; load = 1'b0;
        chk("busy_st.addr", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'h01020304;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("busy_st.done", done, 1'b1);
        chk("busy_st.rdata", rdata_out, 32'h01020304);
        chk("busy_st.rd", rd_out, 5'd12);
        step();
        step();
        chk("busy_st.noreq", mem_req, 1'b0);
        chk("busy_st.nobusy", busy, 1'b0);

        // Ack withheld: request stays up TIMEOUT cycles, then errors out.
        start = 1'b1; load = 1'b1; funct3 = 3'b010; addr = 32'h400; rd_in = 5'd14;
        step();
        start = 1'b0; load = 1'b0;
        n = 0;
        guard = 0;
        while (mem_req === 1'b1 && guard < 40) begin
            n++;
            guard++;
            step();
        end
        chk("to.req_cycles", n, 16);
        chk("to.done", done, 1'b1);
        chk("to.err", err, 1'b1);
        chk("to.wr_en", wr_en_out, 1'b0);
        chk("to.rdata_held", rdata_out, 32'h01020304);
        step();
        chk("to.idle", busy, 1'b0);

        // Reset mid-REQ drops request asynchronously; no done follows.
        start = 1'b1; load = 1'b1; funct3 = 3'b010; addr = 32'h500; rd_in = 5'd15;
        step();
        start = 1'b0; load = 1'b0;
        chk("rstm.req", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstm.req_async", mem_req, 1'b0);
        chk("rstm.busy_async", busy, 1'b0);
        saw_done = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            step();
        end
        chk("rstm.no_done", saw_done, 1'b0);
        chk("rstm.rdata_clr", rdata_out, 32'd0);

        txn("lw_post", 1, 0, 3'b010, 32'h600, 32'h0, 5'd31, 32'h0BADF00D, 1, 1, 4'b1111, 32'h600, 32'h0,
            '{32'h0BADF00D, 5'd31, 1'b0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage between the ALU and the register file write-back path.
- Takes an effective address from the ALU result, store data from register read port 2, and the RV32I size/sign code.
- Runs one req/ack transaction on the data-memory bus.
- Returns a formatted, sign/zero-extended load word with a write-enable and destination index for the register file's memory write-back input, plus a busy signal for core stalling.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ack in REQ before aborting with error; 0 = wait forever.
- ADDR_W, 32, width of address path; mem_addr is word aligned.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request pulse; sampled only in IDLE
- load  in  1  access is a load (has priority if store also high)
- store  in  1  access is a store
- funct3  in  3  RV32I size/sign code
- addr  in  ADDR_W  effective byte address from ALU result
- wdata  in  32  store data (register read port 2)
- rd_in  in  5  destination register index for loads
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: illegal funct3, misalignment (feature), or timeout
- rdata_out  out  32  formatted load data to register-file memory input
- rd_out  out  5  latched rd_in
- wr_en_out  out  1  one-cycle register write strobe: done & load & !err
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  bus completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word

Behaviour:
- Reset: every output is 0, state = IDLE, timeout counter = 0. Reset asserted mid-transaction drops mem_req asynchronously, and no done pulse is produced.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - start with load|store: latch addr/funct3/wdata/rd_in/direction, then go to REQ.
  - start with neither load nor store: ignored.
  - Illegal funct3 (load: 011/110/111; store: anything other than 000/001/010): skip the bus, go to RESP with err=1.
- REQ:
  - mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata held stable until mem_ack.
  - On mem_ack: capture mem_rdata, go to RESP.
  - Counter increments each REQ cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT with no ack: drop mem_req, go to RESP with err=1.
- RESP: done=1 for exactly one cycle, wr_en_out per rule above, then IDLE. rdata_out and rd_out hold their value until the next load completes.
- Latency: start in cycle 0 gives mem_req high from cycle 1. Ack in cycle k gives done in cycle k+1. Minimum start-to-done is 2 cycles.
- start while busy: ignored; no queueing.
- Byte enables (b = addr[1:0]):
  - byte: 4'b0001<<b
  - half: 4'b0011<<b (b[0] ignored unless feature on)
  - word: 4'b1111
- Store data: SB replicates wdata[7:0] x4; SH replicates wdata[15:0] x2; SW passes through.
- Load formatting: select lane by addr[1:0].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- mem_ack outside REQ: ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, performs no bus cycle.
  - Goes IDLE -> RESP with err=1, wr_en_out=0.
- MISALIGN_TRAP_EN undefined: low address bits are ignored for half/word; the access proceeds word/half aligned, with no error.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack in cycle 1 -> mem_addr=0x100, be=1111, done cycle 2, rdata_out=0xDEADBEEF, wr_en_out=1, rd_out=rd_in.
- LB addr=0x103, mem_rdata=0x80FF1234 -> be=1000, rdata_out=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
- SB addr=0x21, wdata=0x000000A5 -> mem_we=1, be=0010, mem_wdata=0xA5A5A5A5, done with wr_en_out=0.
- Ack withheld, TIMEOUT=16 -> mem_req high 16 cycles, then done=1, err=1, wr_en_out=0, busy falls next cycle.
- Reset asserted mid-REQ -> mem_req/busy drop without a clock edge, and no done. start while busy -> no second transaction.
- Feature on, LW addr=0x102 -> no mem_req, done+err at cycle 1. Feature off -> mem_addr=0x100, normal LW.
